// File: rtl/intra_pred_sched.sv
// Intra-prediction block scheduler: walks the 4x4 blocks of a macroblock in z-order and drives the prediction adder.
// Optional WAIT-state timeout watchdog enabled by defining INTRA_SCHED_TIMEOUT_EN.
module intra_pred_sched #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mb_start,
  input  logic       mb_size,
  input  logic       mb_top_avail,
  input  logic       mb_left_avail,
  input  logic       res_valid,
  input  logic [2:0] res_mode,
  output logic       res_ready,
  output logic       pa_enable,
  output logic [2:0] pa_mode,
  input  logic       pa_fb,
  output logic [3:0] blk_idx,
  output logic [1:0] blk_x,
  output logic [1:0] blk_y,
  output logic       top_avail,
  output logic       left_avail,
  output logic       commit,
  output logic       mb_done,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, COMMIT, DONE} state_t;

  state_t     state_reg, state_next;
  logic       size_reg, top_reg, left_reg;
  logic [2:0] pa_mode_reg;
  logic [3:0] blk_idx_reg;
  logic       last_blk;
  logic       timeout_hit;

  assign last_blk = size_reg ? (blk_idx_reg == 4'd0) : (blk_idx_reg == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mb_start) state_next = FETCH;
      FETCH:   if (res_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (pa_fb)            state_next = COMMIT;
        else if (timeout_hit) state_next = IDLE;
      end
      COMMIT:  state_next = last_blk ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_ready = 1'b0;
    pa_enable = 1'b0;
    commit    = 1'b0;
    mb_done   = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      FETCH:   res_ready = 1'b1;
      ISSUE:   pa_enable = 1'b1;
      COMMIT:  commit    = 1'b1;
      DONE:    mb_done   = 1'b1;
      default: ;
    endcase
  end

  // Macroblock context and per-block mode; mode stays put from FETCH until the next block's fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_reg    <= 1'b0;
      top_reg     <= 1'b0;
      left_reg    <= 1'b0;
      pa_mode_reg <= 3'd0;
      blk_idx_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: if (mb_start) begin
          size_reg    <= mb_size;
          top_reg     <= mb_top_avail;
          left_reg    <= mb_left_avail;
          blk_idx_reg <= 4'd0;
        end
        FETCH:   if (res_valid) pa_mode_reg <= res_mode;
        COMMIT:  if (!last_blk) blk_idx_reg <= blk_idx_reg + 4'd1;
        default: ;
      endcase
    end
  end

`ifdef INTRA_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign err         = err_reg;

  // Counter restarts as WAIT is entered; err is sticky until the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && mb_start) err_reg <= 1'b0;
      if (state_reg == ISSUE) cnt_reg <= '0;
      if (state_reg == WAIT && !pa_fb) begin
        if (timeout_hit) err_reg <= 1'b1;
        else             cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  assign pa_mode    = pa_mode_reg;
  assign blk_idx    = blk_idx_reg;
  assign blk_x      = {blk_idx_reg[2], blk_idx_reg[0]};
  assign blk_y      = {blk_idx_reg[3], blk_idx_reg[1]};
  assign top_avail  = (blk_y != 2'd0) | top_reg;
  assign left_avail = (blk_x != 2'd0) | left_reg;

endmodule

// File: tb/tb_intra_pred_sched.sv
// Directed bench for intra_pred_sched: expected blocks are queued at macroblock start and popped on commit.
// Exercises the timeout path when INTRA_SCHED_TIMEOUT_EN is defined, the unbounded WAIT otherwise.
module tb_intra_pred_sched;

  logic       clk;
  logic       reset;
  logic       mb_start, mb_size, mb_top_avail, mb_left_avail;
  logic       res_valid;
  logic [2:0] res_mode;
  logic       res_ready, pa_enable;
  logic [2:0] pa_mode;
  logic       pa_fb;
  logic [3:0] blk_idx;
  logic [1:0] blk_x, blk_y;
  logic       top_avail, left_avail, commit, mb_done, err, busy;

  intra_pred_sched #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .mb_start(mb_start), .mb_size(mb_size),
    .mb_top_avail(mb_top_avail), .mb_left_avail(mb_left_avail),
    .res_valid(res_valid), .res_mode(res_mode), .res_ready(res_ready),
    .pa_enable(pa_enable), .pa_mode(pa_mode), .pa_fb(pa_fb),
    .blk_idx(blk_idx), .blk_x(blk_x), .blk_y(blk_y),
    .top_avail(top_avail), .left_avail(left_avail),
    .commit(commit), .mb_done(mb_done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    int         x;
    int         y;
    bit         top;
    bit         left;
    logic [2:0] mode;
  } exp_t;

  exp_t q[$];
  int   zx[16] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 0, 1, 2, 3, 2, 3};
  int   zy[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};

  int n_vec = 0, n_err = 0;
  int n_commit = 0, n_done = 0, n_en = 0;

  // Adder model: completion flag arrives in the cycle after pa_enable.
  logic fb_auto = 1'b1, fb_force = 1'b0, fb_auto_q = 1'b0, en_prev = 1'b0;
  assign pa_fb = fb_force | fb_auto_q;

  always @(negedge clk) begin
    fb_auto_q = fb_auto & en_prev;
    en_prev   = pa_enable;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor; also drives res_mode, scrambled whenever the scheduler is not fetching.
  always @(negedge clk) begin
    if (reset) begin
      if (busy && q.size() > 0) begin
        chk("blk_idx", blk_idx, q[0].idx);
        chk("blk_x", blk_x, q[0].x);
        chk("blk_y", blk_y, q[0].y);
        chk("top_avail", top_avail, q[0].top);
        chk("left_avail", left_avail, q[0].left);
      end
      if (pa_enable) begin
        n_en++;
        if (q.size() == 0) chk("pa_enable_unexpected", pa_enable, 0);
        else chk("pa_mode_at_enable", pa_mode, q[0].mode);
      end
      if (commit) begin
        n_commit++;
        if (q.size() == 0) chk("commit_unexpected", commit, 0);
        else begin
          chk("pa_mode_at_commit", pa_mode, q[0].mode);
          void'(q.pop_front());
        end
      end
      if (mb_done) n_done++;
      if (q.size() > 0) res_mode = res_ready ? q[0].mode : ~q[0].mode;
    end
  end

  task automatic push_mb(input bit size, input bit t, input bit l, input int base);
    exp_t e;
    int nb;
    nb = size ? 1 : 16;
    for (int k = 0; k < nb; k++) begin
      e.idx  = k;
      e.x    = zx[k];
      e.y    = zy[k];
      e.top  = (zy[k] != 0) || t;
      e.left = (zx[k] != 0) || l;
      e.mode = 3'((base + 3 * k) % 8);
      q.push_back(e);
    end
  endtask

  // Returns at the first negedge after mb_start was sampled.
  task automatic start_mb(input bit size, input bit t, input bit l);
    @(negedge clk);
    mb_size = size; mb_top_avail = t; mb_left_avail = l; mb_start = 1'b1;
    @(negedge clk);
    mb_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!mb_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, mb_done, 1);
    @(negedge clk);
  endtask

  task automatic wait_enable(input string tag);
    int n;
    n = 0;
    while (!pa_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, pa_enable, 1);
  endtask

  initial begin
    int n, c0, d0, e0, w;
    reset = 1'b0; mb_start = 1'b0; mb_size = 1'b0; mb_top_avail = 1'b0;
    mb_left_avail = 1'b0; res_valid = 1'b1; res_mode = 3'd0;
    @(negedge clk);
    chk("reset_outputs", {busy, res_ready, pa_enable, pa_mode, blk_idx, blk_x, blk_y,
                          top_avail, left_avail, commit, mb_done, err}, 0);
    @(negedge clk);
    reset = 1'b1;

    // 16 blocks with no neighbours; mb_done lands in cycle 66 counting mb_start as cycle 1.
    push_mb(0, 0, 0, 1);
    c0 = n_commit; d0 = n_done;
    start_mb(0, 0, 0);
    n = 1;
    while (!mb_done && n < 200) begin
      @(negedge clk);
      n++;
      mb_start = (n == 20);  // a restart while busy must be ignored
    end
    mb_start = 1'b0;
    chk("A_done_latency", n, 65);
    @(negedge clk);
    chk("A_commits", n_commit - c0, 16);
    chk("A_done_pulses", n_done - d0, 1);
    chk("A_queue_drained", q.size(), 0);
    chk("A_idle_after_done", busy, 0);

    // Single 16x16 block, mode 2.
    push_mb(1, 1, 0, 2);
    c0 = n_commit; d0 = n_done; e0 = n_en;
    start_mb(1, 1, 0);
    wait_done("B_done_seen");
    chk("B_enables", n_en - e0, 1);
    chk("B_commits", n_commit - c0, 1);
    chk("B_done_pulses", n_done - d0, 1);

    // Upstream stall of 5 cycles at block 7.
    push_mb(0, 1, 1, 5);
    c0 = n_commit;
    start_mb(0, 1, 1);
    n = 0;
    while (!(res_ready && blk_idx == 4'd7) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("C_reach_blk7", res_ready && blk_idx == 4'd7, 1);
    res_valid = 1'b0;
    e0 = n_en;
    repeat (5) begin
      @(negedge clk);
      chk("C_stall_ready", res_ready, 1);
      chk("C_stall_idx", blk_idx, 7);
    end
    chk("C_stall_no_enable", n_en - e0, 0);
    res_valid = 1'b1;
    wait_done("C_done_seen");
    chk("C_commits", n_commit - c0, 16);

    // Asynchronous reset during WAIT of block 9.
    push_mb(0, 1, 1, 6);
    start_mb(0, 1, 1);
    n = 0;
    while (!(pa_enable && blk_idx == 4'd9) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("D_reach_blk9_issue", pa_enable && blk_idx == 4'd9, 1);
    c0 = n_commit; d0 = n_done;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("D_reset_outputs", {busy, res_ready, pa_enable, pa_mode, blk_idx, blk_x, blk_y,
                            top_avail, left_avail, commit, mb_done, err}, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("D_idle_after_release", busy, 0);
    chk("D_no_commit", n_commit - c0, 0);
    chk("D_no_done", n_done - d0, 0);

    push_mb(0, 0, 1, 3);
    c0 = n_commit;
    start_mb(0, 0, 1);
    wait_done("E_done_seen");
    chk("E_commits", n_commit - c0, 16);

`ifdef INTRA_SCHED_TIMEOUT_EN
    // Adder never answers: 15 WAIT cycles then IDLE with err set.
    push_mb(1, 0, 0, 4);
    c0 = n_commit; d0 = n_done;
    fb_auto = 1'b0;
    start_mb(1, 0, 0);
    wait_enable("T_enable_seen");
    @(negedge clk);
    w = 0;
    while (busy && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk("T_wait_cycles", w, 15);
    chk("T_err_set", err, 1);
    chk("T_no_commit", n_commit - c0, 0);
    chk("T_no_done", n_done - d0, 0);
    q.delete();
    fb_auto = 1'b1;
    push_mb(1, 0, 0, 4);
    start_mb(1, 0, 0);
    chk("T_err_cleared", err, 0);
    wait_done("T_done_seen");
`else
    // Without the watchdog WAIT holds indefinitely and err stays low.
    push_mb(1, 0, 0, 4);
    c0 = n_commit;
    fb_auto = 1'b0;
    start_mb(1, 0, 0);
    wait_enable("W_enable_seen");
    repeat (40) @(negedge clk);
    chk("W_still_busy", busy, 1);
    chk("W_err_low", err, 0);
    chk("W_no_commit", n_commit - c0, 0);
    fb_force = 1'b1;
    @(negedge clk);
    fb_force = 1'b0;
    fb_auto = 1'b1;
    wait_done("W_done_seen");
    chk("W_commits", n_commit - c0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intra_pred_sched.md
INTRA_PRED_SCHED -- requirements
Module: intra_pred_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum number of WAIT-state cycles allowed for pa_fb (used only when INTRA_SCHED_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port mb_start, input, 1 bit: single-cycle pulse that starts one macroblock.
REQ-005 SHALL have port mb_size, input, 1 bit: 0 = sixteen 4x4 blocks, 1 = one 16x16 block; sampled on accepted mb_start.
REQ-006 SHALL have ports mb_top_avail and mb_left_avail, input, 1 bit each: neighbour macroblock exists; sampled on accepted mb_start.
REQ-007 SHALL have port res_valid, input, 1 bit: residue block and mode are presented by the upstream stage.
REQ-008 SHALL have port res_mode, input, 3 bits: intra mode that accompanies the residue block.
REQ-009 SHALL have port res_ready, output, 1 bit: scheduler accepts a residue block.
REQ-010 SHALL have port pa_enable, output, 1 bit: one-cycle enable to the prediction adder.
REQ-011 SHALL have port pa_mode, output, 3 bits: mode driven to the prediction adder.
REQ-012 SHALL have port pa_fb, input, 1 bit: adder completion flag.
REQ-013 SHALL have ports blk_idx (output, 4 bits), blk_x (output, 2 bits) and blk_y (output, 2 bits): current block index and its 4x4 position within the macroblock.
REQ-014 SHALL have ports top_avail and left_avail, output, 1 bit each: neighbour pixels are valid for the current block.
REQ-015 SHALL have ports commit, mb_done and err, output, 1 bit each, and busy, output, 1 bit.
- commit: write-strobe for the reconstruction result into the neighbour buffer.
- mb_done: macroblock-complete pulse.
- err: timeout flag.
- busy: a macroblock is in progress.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, ISSUE, WAIT, COMMIT and DONE.
REQ-017 IDLE->FETCH SHALL occur on mb_start; mb_start in any other state SHALL be ignored.
REQ-018 In FETCH, res_ready=1; on res_valid&&res_ready, res_mode SHALL be latched into pa_mode and the FSM SHALL move to ISSUE.
REQ-019 In ISSUE, pa_enable=1 for exactly one cycle, then the FSM SHALL move to WAIT; pa_mode SHALL be held stable from ISSUE through COMMIT.
REQ-020 In WAIT, the FSM SHALL move to COMMIT on pa_fb=1 at a rising edge; pa_fb in any other state SHALL be ignored.
REQ-021 In COMMIT, commit=1 for one cycle; if blk_idx equals the last index (15, or 0 when mb_size=1), the FSM SHALL go to DONE, otherwise blk_idx SHALL increment and the FSM SHALL return to FETCH.
REQ-022 In DONE, mb_done=1 for one cycle, then the FSM SHALL go to IDLE.
REQ-023 blk_idx SHALL follow H.264 z-order: blk_x={blk_idx[2],blk_idx[0]}, blk_y={blk_idx[3],blk_idx[1]}; blk_idx=0 on start.
REQ-024 top_avail SHALL equal (blk_y!=0)|latched mb_top_avail; left_avail SHALL equal (blk_x!=0)|latched mb_left_avail; both combinational.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Minimum per-block latency SHALL be 4 cycles (FETCH, ISSUE, WAIT with pa_fb=1 on its first edge, COMMIT).
REQ-027 res_ready SHALL be 0 outside FETCH, so the upstream stage stalls with no data loss.

Reset
REQ-028 reset low SHALL asynchronously force IDLE and clear every output, all latched flags, blk_idx and the timeout counter (err=0, pa_mode=0).
REQ-029 Reset asserted mid-macroblock SHALL abandon it with no commit and no mb_done; the first cycle after release SHALL be IDLE.

Configuration
REQ-030 With INTRA_SCHED_TIMEOUT_EN defined:
- A counter SHALL clear on entry to WAIT.
- If TIMEOUT cycles elapse without pa_fb, err SHALL set (sticky) and the FSM SHALL go to IDLE with no commit and no mb_done.
- err SHALL clear on the next accepted mb_start.
REQ-031 Without INTRA_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded, err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-032 mb_size=0, res_valid=1 held, pa_fb returned 1 cycle after pa_enable -> 16 commits, blk_x/blk_y sequence (0,0),(1,0),(0,1),(1,1),(2,0)..., mb_done in cycle 66 after mb_start.
REQ-033 mb_size=1, res_mode=2 -> one pa_enable with pa_mode=2, one commit, mb_done; top_avail=mb_top_avail and left_avail=mb_left_avail throughout.
REQ-034 mb_top_avail=0, mb_left_avail=0 -> blk 0: top_avail=0, left_avail=0; blk 1: left_avail=1; blk 2: top_avail=1.
REQ-035 res_valid deasserted for 5 cycles at blk 7 -> FSM holds FETCH, res_ready=1, no pa_enable, and resumes with blk_idx=7.
REQ-036 reset pulsed low during WAIT of blk 9 -> all outputs 0 immediately; a new mb_start restarts at blk_idx=0.
REQ-037 INTRA_SCHED_TIMEOUT_EN defined, TIMEOUT=15, pa_fb held 0 -> err=1 after 15 WAIT cycles, FSM in IDLE, no mb_done; next mb_start clears err.
